// File: rtl/agc_alu_seq.sv
// agc_alu_seq: ones'-complement arithmetic unit behind the control-pulse sequencer.
// AD/SU/MASK are combinational. MP/DV use a shared iterative engine
// (shift-add multiply, restoring divide) that latches its result words.
module agc_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_lo,
  output logic             busy,
  output logic             done,
  output logic             div_ovf
);

  localparam int M  = WIDTH - 1;       // magnitude field width
  localparam int CW = $clog2(WIDTH);   // iteration counter width
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

  localparam logic [2:0] OP_AD   = 3'd0;
  localparam logic [2:0] OP_SU   = 3'd1;
  localparam logic [2:0] OP_MASK = 3'd2;
  localparam logic [2:0] OP_MP0  = 3'd3;
  localparam logic [2:0] OP_MP1  = 3'd4;
  localparam logic [2:0] OP_DV0  = 3'd5;
  localparam logic [2:0] OP_DV1  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Handshake: start is accepted in a cycle where busy is low and alu_op is
  // MP0 or DV0. busy is high for the WIDTH-1 iteration cycles that follow;
  // done pulses for one cycle right after them, with busy already low, so a
  // start in the done cycle is accepted immediately. Latched words are valid
  // from the done cycle on and hold until the next done or reset.

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [M-1:0]  acc_q;   // product high half (MP) or partial remainder (DV)
  logic [M-1:0]  q_q;     // multiplier shifting out (MP) or quotient shifting in (DV)
  logic [M-1:0]  b_q;     // multiplicand (MP) or divisor (DV)
  logic          sx_q, sy_q;
  logic [WIDTH-1:0] x_q;  // raw dividend word, returned as remainder on overflow
  logic          ovf_q;   // overflow decided at capture, published at done
  logic [WIDTH-1:0] hi_q, lo_q;
  logic          div_ovf_q;

  function automatic logic [M-1:0] mag_of(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ~v[M-1:0] : v[M-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [M-1:0] m);
    return neg ? ~{1'b0, m} : {1'b0, m};
  endfunction

  logic [M-1:0] mag_x, mag_y;
  logic         accept, last_iter;

  assign mag_x     = mag_of(x);
  assign mag_y     = mag_of(y);
  assign accept    = start && !busy && (alu_op == OP_MP0 || alu_op == OP_DV0);
  assign last_iter = (state_q == S_MUL || state_q == S_DIV) && (cnt_q == LAST);

  // One iteration step of each engine, plus the signed words formed on the last step.
  logic [M:0]       mul_sum;
  logic [M-1:0]     mul_acc_nxt, mul_q_nxt;
  logic [M:0]       div_shift;
  logic             div_ge;
  logic [M-1:0]     div_diff, div_r_nxt, div_q_nxt;
  logic             mp_neg;
  logic [WIDTH-1:0] mp_hi, mp_lo, dv_hi, dv_lo;

  always_comb begin
    mul_sum     = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
    mul_acc_nxt = mul_sum[M:1];
    mul_q_nxt   = {mul_sum[0], q_q[M-1:1]};

    div_shift   = {acc_q, 1'b0};
    div_ge      = div_shift >= {1'b0, b_q};
    div_diff    = div_shift[M-1:0] - b_q;
    div_r_nxt   = div_ge ? div_diff : div_shift[M-1:0];
    div_q_nxt   = {q_q[M-2:0], div_ge};

    mp_neg = (sx_q ^ sy_q) && ((mul_acc_nxt | mul_q_nxt) != '0);
    mp_hi  = apply_sign(mp_neg, mul_acc_nxt);
    mp_lo  = apply_sign(mp_neg, mul_q_nxt);

    if (ovf_q) begin
      dv_hi = apply_sign(sx_q ^ sy_q, {M{1'b1}});
      dv_lo = x_q;
    end else begin
      dv_hi = apply_sign((sx_q ^ sy_q) && (div_q_nxt != '0), div_q_nxt);
      dv_lo = apply_sign(sx_q && (div_r_nxt != '0), div_r_nxt);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a start in DONE goes straight to the new run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept)  state_d = (alu_op == OP_MP0) ? S_MUL : S_DIV;
        else         state_d = S_IDLE;
      end
      S_MUL:   if (cnt_q == LAST) state_d = S_DONE;
      S_DIV:   if (cnt_q == LAST) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == S_MUL) || (state_q == S_DIV);
    done = (state_q == S_DONE);
  end

  // Engine datapath: operand capture, iteration, result latching on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      x_q       <= '0;
      ovf_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_ovf_q <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      sx_q      <= x[WIDTH-1];
      sy_q      <= y[WIDTH-1];
      x_q       <= x;
      div_ovf_q <= 1'b0;
      if (alu_op == OP_MP0) begin
        acc_q <= '0;
        q_q   <= mag_y;
        b_q   <= mag_x;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= mag_x;
        q_q   <= '0;
        b_q   <= mag_y;
        ovf_q <= (mag_x >= mag_y);
      end
    end else if (state_q == S_MUL) begin
      acc_q <= mul_acc_nxt;
      q_q   <= mul_q_nxt;
      cnt_q <= cnt_q + CW'(1);
      if (last_iter) begin
        hi_q <= mp_hi;
        lo_q <= mp_lo;
      end
    end else if (state_q == S_DIV) begin
      acc_q <= div_r_nxt;
      q_q   <= div_q_nxt;
      cnt_q <= cnt_q + CW'(1);
      if (last_iter) begin
        hi_q      <= dv_hi;
        lo_q      <= dv_lo;
        div_ovf_q <= ovf_q;
      end
    end
  end

  assign div_ovf = div_ovf_q;

  // Result mux: combinational ops from x/y, engine ops from the latches.
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] add_res;

  always_comb begin
    add_b   = (alu_op == OP_SU) ? ~y : y;
    add_sum = {1'b0, x} + {1'b0, add_b};
    add_res = add_sum[WIDTH-1:0] + {{M{1'b0}}, add_sum[WIDTH]};
    result    = '0;
    result_lo = '0;
    case (alu_op)
      OP_AD, OP_SU: result = add_res;
      OP_MASK:      result = x & y;
      OP_MP0, OP_MP1, OP_DV0, OP_DV1: begin
        result    = hi_q;
        result_lo = lo_q;
      end
      default: begin
        result    = '0;
        result_lo = '0;
      end
    endcase
  end

endmodule
